// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and op decode helpers for the load/store
//               alignment unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [3:0] {
    OP_SW  = 4'd0,
    OP_SH  = 4'd1,
    OP_SB  = 4'd2,
    OP_LW  = 4'd3,
    OP_LH  = 4'd4,
    OP_LB  = 4'd5,
    OP_LBU = 4'd6,
    OP_LHU = 4'd7,
    OP_LWU = 4'd8,
    OP_SD  = 4'd9,
    OP_LD  = 4'd10
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_WR0  = 3'd2,
    ST_RD1  = 3'd3,
    ST_WR1  = 3'd4,
    ST_DONE = 3'd5
  } lsu_state_e;

  // Access size in bytes; 0 marks an undefined op code.
  function automatic logic [3:0] op_size(input logic [3:0] op);
    case (mem_op_e'(op))
      OP_SB, OP_LB, OP_LBU: op_size = 4'd1;
      OP_SH, OP_LH, OP_LHU: op_size = 4'd2;
      OP_SW, OP_LW, OP_LWU: op_size = 4'd4;
      OP_SD, OP_LD:         op_size = 4'd8;
      default:              op_size = 4'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    case (mem_op_e'(op))
      OP_SW, OP_SH, OP_SB, OP_SD: op_is_store = 1'b1;
      default:                    op_is_store = 1'b0;
    endcase
  endfunction

  function automatic logic op_signed(input logic [3:0] op);
    case (mem_op_e'(op))
      OP_LB, OP_LH, OP_LW: op_signed = 1'b1;
      default:             op_signed = 1'b0;
    endcase
  endfunction

  // Doubleword ops only exist when the data path is at least 64 bits wide.
  function automatic logic op_legal(input logic [3:0] op, input int xlen);
    op_legal = (op_size(op) != 4'd0) && ((int'(op_size(op)) * 8) <= xlen);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_merge.sv
`default_nettype none
// ============================================================================
// Module      : lsu_byte_merge
// Description : Replaces the addressed bytes of a memory word with store
//               data. i_hi selects the second word of a boundary-crossing
//               store, which receives the store bytes left over from word 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_byte_merge #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]            i_word,
  input  logic [XLEN-1:0]            i_data,
  input  logic [$clog2(XLEN/8)-1:0]  i_off,
  input  logic [3:0]                 i_size,
  input  logic                       i_hi,
  output logic [XLEN-1:0]            o_merged
);

  localparam int c_nb = XLEN / 8;

  int w_k;

  // Byte i of the word takes store byte k when 0 <= k < size.
  always_comb begin
    o_merged = i_word;
    w_k      = 0;
    for (int i = 0; i < c_nb; i++) begin
      w_k = i_hi ? (i + c_nb - int'(i_off)) : (i - int'(i_off));
      if ((w_k >= 0) && (w_k < int'(i_size))) begin
        o_merged[8*i +: 8] = i_data[8*w_k +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu_align_seq.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_seq
// Description : Sequential load/store alignment unit. Loads read one or two
//               words and extract/extend the addressed bytes; stores do a
//               read-modify-write of one or two words.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align_seq
  import lsu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] load_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam int c_nb   = XLEN / 8;
  localparam int c_offw = $clog2(c_nb);

  lsu_state_e       r_state, w_next;
  logic [3:0]       r_op;
  logic [XLEN-1:0]  r_addr, r_sdata, r_word0, r_word1, r_load;
  logic             r_err, r_cross;

  logic [c_offw-1:0] w_in_off, w_off;
  logic [3:0]        w_in_size, w_size;
  logic              w_in_cross, w_in_bad, w_store;
  logic [XLEN-1:0]   w_wa0, w_wa1;
  logic [XLEN-1:0]   w_merge_word, w_merged;
  logic              w_merge_hi;
  logic [XLEN-1:0]   w_lo, w_hi, w_shifted, w_extract;
  logic              w_sbit, w_sign;

  // Command decode on the raw inputs decides at accept time between the
  // memory path and the immediate error path.
  assign w_in_off   = addr[c_offw-1:0];
  assign w_in_size  = op_size(op);
  assign w_in_cross = (int'(w_in_off) + int'(w_in_size)) > c_nb;
  assign w_in_bad   = !op_legal(op, XLEN) || (w_in_cross && !SPLIT_EN);

  assign w_off   = r_addr[c_offw-1:0];
  assign w_size  = op_size(r_op);
  assign w_store = op_is_store(r_op);
  assign w_wa0   = {r_addr[XLEN-1:c_offw], {c_offw{1'b0}}};
  assign w_wa1   = w_wa0 + XLEN'(c_nb);

  assign w_merge_hi   = (r_state == ST_WR1);
  assign w_merge_word = w_merge_hi ? r_word1 : r_word0;

  lsu_byte_merge #(.XLEN(XLEN)) u_merge (
    .i_word   (w_merge_word),
    .i_data   (r_sdata),
    .i_off    (w_off),
    .i_size   (w_size),
    .i_hi     (w_merge_hi),
    .o_merged (w_merged)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and bus/status outputs, all decoded from the current state.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = w_in_bad ? ST_DONE : ST_RD0;
      end
      ST_RD0: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = w_wa0;
        if (mem_ack) w_next = w_store ? ST_WR0 : (r_cross ? ST_RD1 : ST_DONE);
      end
      ST_WR0: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_wa0;
        mem_wdata = w_merged;
        if (mem_ack) w_next = r_cross ? ST_RD1 : ST_DONE;
      end
      ST_RD1: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = w_wa1;
        if (mem_ack) w_next = w_store ? ST_WR1 : ST_DONE;
      end
      ST_WR1: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_wa1;
        mem_wdata = w_merged;
        if (mem_ack) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        err    = r_err;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Load extract: the word being acknowledged this cycle is taken straight
  // from the bus so the result is ready on entry to DONE.
  always_comb begin
    w_lo      = (r_state == ST_RD0) ? mem_rdata : r_word0;
    w_hi      = (r_state == ST_RD1) ? mem_rdata : r_word1;
    w_shifted = XLEN'({w_hi, w_lo} >> {w_off, 3'b000});
    case (w_size)
      4'd1:    w_sbit = w_shifted[7];
      4'd2:    w_sbit = w_shifted[15];
      4'd4:    w_sbit = w_shifted[31];
      default: w_sbit = 1'b0;
    endcase
    w_sign    = w_sbit & op_signed(r_op);
    w_extract = w_shifted;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= 8 * int'(w_size)) w_extract[i] = w_sign;
    end
  end

  // Command latch, captured read words and the held load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= '0;
      r_addr  <= '0;
      r_sdata <= '0;
      r_word0 <= '0;
      r_word1 <= '0;
      r_load  <= '0;
      r_err   <= 1'b0;
      r_cross <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_op    <= op;
        r_addr  <= addr;
        r_sdata <= store_data;
        r_err   <= w_in_bad;
        r_cross <= w_in_cross;
      end
      if ((r_state == ST_RD0) && mem_ack) r_word0 <= mem_rdata;
      if ((r_state == ST_RD1) && mem_ack) r_word1 <= mem_rdata;
      if ((w_next == ST_DONE) && !w_store &&
          ((r_state == ST_RD0) || (r_state == ST_RD1))) begin
        r_load <= w_extract;
      end
    end
  end

  assign load_data = r_load;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_align_seq
// Description : Self-checking bench for lsu_align_seq with a byte-level
//               memory/reference model and a randomised wait-state responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_align_seq;

  logic        clk = 1'b0;
  logic        reset, start, b_start;
  logic [3:0]  op;
  logic [63:0] addr, store_data;
  logic        busy, done, err;
  logic [63:0] load_data;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        b_busy, b_done, b_err, b_mem_req, b_mem_we, b_mem_ack;
  logic [63:0] b_load_data, b_mem_addr, b_mem_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_align_seq #(.XLEN(64), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  assign b_mem_ack = b_mem_req;

  lsu_align_seq #(.XLEN(64), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .start(b_start), .op(op), .addr(addr),
    .store_data(store_data), .busy(b_busy), .done(b_done), .err(b_err),
    .load_data(b_load_data), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(64'h0),
    .mem_ack(b_mem_ack)
  );

  // ---------------- memory model ----------------
  logic [63:0] mem [logic [63:0]];
  logic [64:0] log_q [$];
  int          req_cycles = 0;
  int          wait_mode = 0;
  bit          noise_en = 1'b0, hold_en = 1'b0;
  logic [63:0] hold_addr = '0;
  logic [63:0] exp_ld = '0;

  logic        c_fire = 1'b0, c_pend = 1'b0, c_we = 1'b0, c_req = 1'b0;
  logic [63:0] c_addr = '0, c_wdata = '0;

  function automatic logic [63:0] rd_word(input logic [63:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {wa[31:0] ^ 32'h5A5A_C3C3, ~wa[31:0]};
  endfunction

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    logic [63:0] w;
    w = rd_word({a[63:3], 3'b000});
    return w[8*a[2:0] +: 8];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Capture the bus as seen by each active edge.
  always @(posedge clk) begin
    c_fire  <= !reset && mem_req && mem_ack;
    c_pend  <= !reset && mem_req && !mem_ack;
    c_req   <= mem_req;
    c_we    <= mem_we;
    c_addr  <= mem_addr;
    c_wdata <= mem_wdata;
  end

  // Responder: commit the previous transfer, check bus stability, then
  // decide the acknowledge for the current cycle.
  always @(negedge clk) begin
    if (c_fire) begin
      log_q.push_back({c_we, c_addr});
      if (c_we) mem[c_addr] = c_wdata;
    end
    if (c_req) req_cycles++;
    if (c_pend) begin
      check("bus_stable_req", {63'd0, mem_req}, 64'd1);
      check("bus_stable_addr", mem_addr, c_addr);
      check("bus_stable_wdata", {mem_wdata[63:1], mem_we}, {c_wdata[63:1], c_we});
    end
    if (mem_req && !(hold_en && mem_addr == hold_addr) &&
        (wait_mode == 0 || $urandom_range(0, 2) == 0)) begin
      mem_ack   = 1'b1;
      mem_rdata = rd_word(mem_addr);
    end else begin
      mem_ack   = (noise_en && !mem_req) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = {$urandom, $urandom};
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [3:0] o);
    case (o)
      4'd2, 4'd5, 4'd6: return 1;
      4'd1, 4'd4, 4'd7: return 2;
      4'd0, 4'd3, 4'd8: return 4;
      4'd9, 4'd10:      return 8;
      default:          return 0;
    endcase
  endfunction

  task automatic do_access(input logic [3:0] o, input logic [63:0] a,
                           input logic [63:0] sd, input string tag);
    int          sz, off, lat;
    bit          legal, st, sg, cr;
    logic [63:0] wa0, wa1, e0, e1, b;
    logic [64:0] exp_q [$];
    sz    = ref_size(o);
    legal = (sz != 0);
    st    = (o == 4'd0 || o == 4'd1 || o == 4'd2 || o == 4'd9);
    sg    = (o == 4'd3 || o == 4'd4 || o == 4'd5);
    off   = int'(a[2:0]);
    cr    = (off + sz) > 8;
    wa0   = a - 64'(off);
    wa1   = wa0 + 64'd8;
    e0    = rd_word(wa0);
    e1    = rd_word(wa1);
    if (legal) begin
      exp_q.push_back({1'b0, wa0});
      if (st) exp_q.push_back({1'b1, wa0});
      if (cr) exp_q.push_back({1'b0, wa1});
      if (cr && st) exp_q.push_back({1'b1, wa1});
      if (st) begin
        for (int i = 0; i < sz; i++) begin
          b = a + 64'(i);
          if ({b[63:3], 3'b000} == wa0) e0[8*b[2:0] +: 8] = sd[8*i +: 8];
          else                          e1[8*b[2:0] +: 8] = sd[8*i +: 8];
        end
      end else begin
        exp_ld = '0;
        for (int i = 0; i < sz; i++) exp_ld[8*i +: 8] = rd_byte(a + 64'(i));
        if (sg && sz < 8 && exp_ld[8*sz-1]) exp_ld = exp_ld | ~((64'd1 << (8*sz)) - 64'd1);
      end
    end
    log_q.delete();
    start = 1'b1; op = o; addr = a; store_data = sd;
    lat = 1;
    tick();
    start = 1'b0; op = 4'($urandom); addr = {$urandom, $urandom}; store_data = {$urandom, $urandom};
    lat = 2;
    if (legal) check({tag, ":busy"}, {63'd0, busy}, 64'd1);
    while (!done && lat < 300) begin
      tick();
      lat++;
    end
    check({tag, ":done"}, {63'd0, done}, 64'd1);
    check({tag, ":busy_at_done"}, {63'd0, busy}, 64'd0);
    check({tag, ":err"}, {63'd0, err}, {63'd0, !legal});
    check({tag, ":load_data"}, load_data, exp_ld);
    if (wait_mode == 0) check({tag, ":latency"}, 64'(lat), 64'(2 + exp_q.size()));
    tick();
    check({tag, ":done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, ":nreq"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check({tag, ":req"}, log_q[i][63:0] ^ {63'd0, log_q[i][64]}, exp_q[i][63:0] ^ {63'd0, exp_q[i][64]});
    if (legal && st) begin
      check({tag, ":word0"}, rd_word(wa0), e0);
      check({tag, ":word1"}, rd_word(wa1), e1);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          n;
    int          brq;
    bit          seen;
    logic [3:0]  ro;
    logic [63:0] ra;
    reset = 1'b1; start = 1'b0; b_start = 1'b0; op = '0; addr = '0; store_data = '0;
    repeat (3) tick();
    check("rst:busy", {63'd0, busy}, 64'd0);
    check("rst:done", {63'd0, done}, 64'd0);
    check("rst:err", {63'd0, err}, 64'd0);
    check("rst:load_data", load_data, 64'd0);
    check("rst:mem_req", {63'd0, mem_req}, 64'd0);
    check("rst:mem_addr", mem_addr, 64'd0);
    check("rst:mem_wdata", mem_wdata, 64'd0);
    reset = 1'b0;
    tick();

    mem[64'h1000] = 64'h0000_0000_80FF_0000;
    do_access(4'd5, 64'h1003, 64'd0, "lb");
    check("lb:const", load_data, 64'hFFFF_FFFF_FFFF_FF80);
    do_access(4'd6, 64'h1003, 64'd0, "lbu");
    check("lbu:const", load_data, 64'h0000_0000_0000_0080);
    mem[64'h1000] = 64'hDEADBEEF_12345678;
    do_access(4'd8, 64'h1004, 64'd0, "lwu");
    check("lwu:const", load_data, 64'h0000_0000_DEAD_BEEF);

    mem[64'h2000] = 64'h1111_1111_1111_1111;
    do_access(4'd1, 64'h2006, 64'h0000_0000_0000_ABCD, "sh");
    check("sh:const", rd_word(64'h2000), 64'hABCD_1111_1111_1111);

    mem[64'h3000] = 64'h5678_0000_0000_0000;
    mem[64'h3008] = 64'h0000_0000_0000_1234;
    do_access(4'd3, 64'h3006, 64'd0, "lw_cross");
    check("lw_cross:const", load_data, 64'h0000_0000_1234_5678);

    do_access(4'd13, 64'h3000, 64'd0, "illegal13");
    do_access(4'd9, 64'h6003, 64'h0102_0304_0506_0708, "sd_cross");
    do_access(4'd10, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, "ld_wrap");

    // Unsplit instance: crossing access must error without memory traffic.
    op = 4'd3; addr = 64'h3006; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0; brq = 0;
    while (!b_done && n < 20) begin
      if (b_mem_req) brq++;
      tick();
      n++;
    end
    check("nosplit:done", {63'd0, b_done}, 64'd1);
    check("nosplit:err", {63'd0, b_err}, 64'd1);
    check("nosplit:req_cycles", 64'(brq), 64'd0);
    check("nosplit:load_data", b_load_data, 64'd0);

    // Reset while the second read is stalled.
    hold_en = 1'b1; hold_addr = 64'h3008;
    start = 1'b1; op = 4'd3; addr = 64'h3006;
    tick();
    start = 1'b0;
    n = 0;
    while (!(mem_req && mem_addr == 64'h3008) && n < 50) begin
      tick();
      n++;
    end
    check("rstmid:reach_rd1", {63'd0, mem_req && mem_addr == 64'h3008}, 64'd1);
    tick();
    reset = 1'b1;
    tick();
    check("rstmid:mem_req", {63'd0, mem_req}, 64'd0);
    check("rstmid:busy", {63'd0, busy}, 64'd0);
    check("rstmid:done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("rstmid:no_done", {63'd0, seen}, 64'd0);
    hold_en = 1'b0;
    exp_ld = '0;
    check("rstmid:load_cleared", load_data, 64'd0);
    do_access(4'd9, 64'h5000, 64'hCAFE_F00D_1234_5678, "sd_after_rst");
    do_access(4'd10, 64'h5000, 64'd0, "ld_after_rst");

    // Random accesses with wait states and stray acknowledges.
    for (int k = 0; k < 40; k++) begin
      wait_mode = $urandom_range(0, 1);
      noise_en  = 1'($urandom_range(0, 1));
      ro = ($urandom_range(0, 15) < 13) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(11, 15));
      ra = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7)))
                                       : (64'h4000 + 64'($urandom_range(0, 63)));
      do_access(ro, ra, {$urandom, $urandom}, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
